// File: rtl/dmem_arbiter_if.sv
// Per-requester bus into the data-memory arbiter: request fields in,
// grant and one-cycle-later response out.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [2:0]            ctrl;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, ctrl, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, ctrl, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Misaligned/illegal accesses are consumed with an error response, never written.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         port0,
  dmem_arbiter_if.slave         port1,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [2:0]            mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  function automatic logic bad_access(input logic [2:0] ctrl, input logic [1:0] lo);
    logic bad;
    case (ctrl[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic                  last_gnt_r;
  logic                  gnt0_s;
  logic                  gnt1_s;
  logic                  bad0_s;
  logic                  bad1_s;
  logic                  rvalid0_r;
  logic                  rvalid1_r;
  logic                  err0_r;
  logic                  err1_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;

  assign bad0_s = bad_access(port0.ctrl, port0.addr[1:0]);
  assign bad1_s = bad_access(port1.ctrl, port1.addr[1:0]);

  // Grant selection; on a tie the port not granted last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (port0.req && (!port1.req || last_gnt_r)) begin
      gnt0_s = 1'b1;
    end else if (port1.req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Memory port mux: mirrors the granted requester, zero when idle.
  always_comb begin
    mem_a    = '0;
    mem_we   = 1'b0;
    mem_ctrl = 3'b000;
    mem_wd   = '0;
    if (gnt0_s) begin
      mem_a    = {port0.addr[DATA_WIDTH-1:ADDR_BITS], port0.addr[ADDR_BITS-1:0]};
      mem_we   = port0.we && !bad0_s;
      mem_ctrl = port0.ctrl;
      mem_wd   = port0.wdata;
    end else if (gnt1_s) begin
      mem_a    = {port1.addr[DATA_WIDTH-1:ADDR_BITS], port1.addr[ADDR_BITS-1:0]};
      mem_we   = port1.we && !bad1_s;
      mem_ctrl = port1.ctrl;
      mem_wd   = port1.wdata;
    end else begin
      mem_a    = '0;
      mem_we   = 1'b0;
      mem_ctrl = 3'b000;
      mem_wd   = '0;
    end
  end

  // Round-robin history and one-cycle response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r <= 1'b1;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
    end else begin
      if (gnt0_s) begin
        last_gnt_r <= 1'b0;
      end else if (gnt1_s) begin
        last_gnt_r <= 1'b1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
      rvalid0_r <= gnt0_s;
      rvalid1_r <= gnt1_s;
      err0_r    <= gnt0_s && bad0_s;
      err1_r    <= gnt1_s && bad1_s;
      rdata0_r  <= (gnt0_s && !port0.we && !bad0_s) ? mem_rd : '0;
      rdata1_r  <= (gnt1_s && !port1.we && !bad1_s) ? mem_rd : '0;
    end
  end

  // Responses are masked while reset is held so a grant right before reset is dropped.
  assign port0.gnt    = gnt0_s;
  assign port1.gnt    = gnt1_s;
  assign port0.rvalid = rvalid0_r && !rst;
  assign port1.rvalid = rvalid1_r && !rst;
  assign port0.err    = err0_r && !rst;
  assign port1.err    = err1_r && !rst;
  assign port0.rdata  = rst ? '0 : rdata0_r;
  assign port1.rdata  = rst ? '0 : rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  dmem_arbiter_if #(.DATA_WIDTH(32)) p0 ();
  dmem_arbiter_if #(.DATA_WIDTH(32)) p1 ();

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .port0    (p0),
    .port1    (p1),
    .mem_a    (mem_a),
    .mem_we   (mem_we),
    .mem_ctrl (mem_ctrl),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  // Environment memory seen by the DUT (256 bytes, address wraps on bits [7:0]).
  logic [7:0]  env_mem [0:255];
  logic [7:0]  ei;
  logic [31:0] ew;

  always_comb begin
    ei = mem_a[7:0];
    ew = {env_mem[ei + 8'd3], env_mem[ei + 8'd2], env_mem[ei + 8'd1], env_mem[ei]};
    case (mem_ctrl[1:0])
      2'b00:   mem_rd = mem_ctrl[2] ? {24'd0, ew[7:0]}  : {{24{ew[7]}}, ew[7:0]};
      2'b01:   mem_rd = mem_ctrl[2] ? {16'd0, ew[15:0]} : {{16{ew[15]}}, ew[15:0]};
      default: mem_rd = ew;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_a[7:0]] <= mem_wd[7:0];
      if (mem_ctrl[1:0] != 2'b00) env_mem[mem_a[7:0] + 8'd1] <= mem_wd[15:8];
      if (mem_ctrl[1:0] == 2'b10) begin
        env_mem[mem_a[7:0] + 8'd2] <= mem_wd[23:16];
        env_mem[mem_a[7:0] + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  // Reference model state.
  logic [7:0]  sh [0:255];
  int          m_last;
  logic        exp_rv  [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic        obs_gnt0, obs_gnt1, obs_we, obs_rv0, obs_rv1, obs_err0;
  logic [31:0] obs_rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
    int          n;
    logic [31:0] v;
    logic [31:0] idx;
    n = 1 << c[1:0];
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      idx = (a + 32'(k)) & 32'hFF;
      v   = v | (32'(sh[idx[7:0]]) << (8 * k));
    end
    if (!c[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic drive(input int p, input logic rq, input logic w, input logic [31:0] a,
                       input logic [2:0] c, input logic [31:0] d);
    if (p == 0) begin
      p0.req = rq; p0.we = w; p0.addr = a; p0.ctrl = c; p0.wdata = d;
    end else begin
      p1.req = rq; p1.we = w; p1.addr = a; p1.ctrl = c; p1.wdata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
  endtask

  // One cycle: compare DUT at the falling edge against the model, then advance the model.
  task automatic step();
    logic        rq [2];
    logic        wv [2];
    logic [31:0] ad [2];
    logic [2:0]  ct [2];
    logic [31:0] wd [2];
    int          w;
    logic        bad;
    logic [31:0] idx;
    logic        want_rv0, want_rv1;
    @(negedge clk);
    rq[0] = p0.req; wv[0] = p0.we; ad[0] = p0.addr; ct[0] = p0.ctrl; wd[0] = p0.wdata;
    rq[1] = p1.req; wv[1] = p1.we; ad[1] = p1.addr; ct[1] = p1.ctrl; wd[1] = p1.wdata;
    w = -1;
    if (!rst) begin
      if (rq[0] && rq[1]) w = 1 - m_last;
      else if (rq[0])     w = 0;
      else if (rq[1])     w = 1;
    end
    bad = 1'b0;
    if (w >= 0) bad = (ct[w][1:0] == 2'd3) || ((ad[w] % (32'd1 << ct[w][1:0])) != 32'd0);

    check("gnt0",   32'(p0.gnt), 32'(w == 0));
    check("gnt1",   32'(p1.gnt), 32'(w == 1));
    check("mem_we", 32'(mem_we), 32'((w >= 0) && wv[w] && !bad));
    check("mem_a",  mem_a,  (w >= 0) ? ad[w] : 32'd0);
    check("mem_wd", mem_wd, (w >= 0) ? wd[w] : 32'd0);
    want_rv0 = !rst && exp_rv[0];
    want_rv1 = !rst && exp_rv[1];
    check("rvalid0", 32'(p0.rvalid), 32'(want_rv0));
    check("rvalid1", 32'(p1.rvalid), 32'(want_rv1));
    check("err0", 32'(p0.err), 32'(want_rv0 && exp_err[0]));
    check("err1", 32'(p1.err), 32'(want_rv1 && exp_err[1]));
    if (want_rv0) check("rdata0", p0.rdata, exp_rd[0]);
    if (want_rv1) check("rdata1", p1.rdata, exp_rd[1]);

    obs_gnt0 = p0.gnt; obs_gnt1 = p1.gnt; obs_we = mem_we;
    obs_rv0 = p0.rvalid; obs_rv1 = p1.rvalid; obs_err0 = p0.err; obs_rd0 = p0.rdata;

    if (rst) begin
      m_last = 1;
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'd0;
      end
      if (w >= 0) begin
        m_last     = w;
        exp_rv[w]  = 1'b1;
        exp_err[w] = bad;
        exp_rd[w]  = (bad || wv[w]) ? 32'd0 : ref_load(ad[w], ct[w]);
        if (!bad && wv[w]) begin
          for (int k = 0; k < (1 << ct[w][1:0]); k++) begin
            idx = (ad[w] + 32'(k)) & 32'hFF;
            sh[idx[7:0]] = wd[w][8*k +: 8];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  v;
    logic [31:0] a;
    logic [2:0]  c;
    logic [31:0] r1;
    logic [5:0]  seq;
    logic        both;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      env_mem[i] <= v;
      sh[i] = v;
    end
    m_last = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0; exp_err[p] = 1'b0; exp_rd[p] = 32'd0;
    end

    // Reset held with both ports requesting, then a tie right after release.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 3'b010, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h0001_0004, 3'b010, 32'd0);
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    step();
    check("first_tie_gnt0", 32'(obs_gnt0), 32'd1);
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    step();
    check("second_gnt1", 32'(obs_gnt1), 32'd1);
    check("second_rv0",  32'(obs_rv0),  32'd1);
    idle();
    step();
    check("third_rv1", 32'(obs_rv1), 32'd1);
    step();

    // Port 1 stores a word, port 0 reads it back.
    drive(1, 1'b1, 1'b1, 32'h0001_0000, 3'b010, 32'hDEAD_BEEF);
    step();
    idle();
    step();
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 3'b010, 32'd0);
    step();
    idle();
    step();
    check("load_word", obs_rd0, 32'hDEAD_BEEF);

    // Signed then unsigned byte load, back to back.
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 3'b000, 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 3'b100, 32'd0);
    step();
    r1 = obs_rd0;
    check("byte_signed", r1, 32'hFFFF_FFEF);
    idle();
    step();
    check("byte_unsigned", obs_rd0, 32'h0000_00EF);

    // Misaligned word store is rejected and leaves memory untouched.
    drive(0, 1'b1, 1'b1, 32'h0001_0002, 3'b010, 32'h1234_5678);
    step();
    check("misaligned_we", 32'(obs_we), 32'd0);
    idle();
    step();
    check("misaligned_rv",  32'(obs_rv0),  32'd1);
    check("misaligned_err", 32'(obs_err0), 32'd1);
    drive(0, 1'b1, 1'b0, 32'h0001_0000, 3'b010, 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 32'h0001_0004, 3'b010, 32'd0);
    step();
    check("after_misaligned", obs_rd0, 32'hDEAD_BEEF);
    idle();
    step();

    // Port 1 goes last, then six cycles of contention.
    drive(1, 1'b1, 1'b0, 32'h0001_0008, 3'b010, 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 32'h0001_0010, 3'b010, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h0001_0020, 3'b001, 32'd0);
    seq  = 6'd0;
    both = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seq[i] = obs_gnt1;
      both   = both | (obs_gnt0 & obs_gnt1);
    end
    check("alternate", 32'(seq), 32'(6'b101010));
    check("never_both", 32'(both), 32'd0);
    idle();
    step();

    // Reset in the cycle after a port-1 grant drops its response.
    drive(1, 1'b1, 1'b0, 32'h0001_0030, 3'b010, 32'd0);
    step();
    idle();
    rst = 1'b1;
    step();
    check("rst_drops_rv1", 32'(obs_rv1), 32'd0);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0001_0040, 3'b010, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h0001_0044, 3'b010, 32'd0);
    step();
    check("post_rst_tie", 32'(obs_gnt0), 32'd1);
    idle();
    step();

    // Random traffic including sporadic resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++) begin
        c = 3'($urandom_range(0, 7));
        a = 32'h0001_0000 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << c[1:0]) - 32'd1);
        drive(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, c, $urandom);
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the address, write-data and read-data buses.
REQ-002 Parameter ADDR_BITS, default 17, SHALL set the number of low address bits checked and forwarded; upper bits pass through unchanged.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req0/req1  in  1  SHALL be the per-requester access request (0 = pipeline MEM stage, 1 = loader/DMA port).
REQ-006 we0/we1  in  1  SHALL select store (1) or load (0).
REQ-007 addr0/addr1  in  DATA_WIDTH  SHALL carry the byte address.
REQ-008 ctrl0/ctrl1  in  3  SHALL carry addressing control: [1:0] 00 byte, 01 half, 10 word, 11 illegal; [2] zero-extend.
REQ-009 wdata0/wdata1  in  DATA_WIDTH  SHALL carry store data.
REQ-010 gnt0/gnt1  out  1  SHALL flag, combinationally, that this cycle's request is accepted.
REQ-011 rvalid0/rvalid1  out  1  SHALL pulse one cycle after an accepted access.
REQ-012 rdata0/rdata1  out  DATA_WIDTH  SHALL hold registered load data, valid while rvalid is high.
REQ-013 err0/err1  out  1  SHALL flag, alongside rvalid, an access rejected as misaligned or illegal.
REQ-014 mem_a, mem_we, mem_ctrl, mem_wd  out  DATA_WIDTH/1/3/DATA_WIDTH  SHALL drive the data memory port.
REQ-015 mem_rd  in  DATA_WIDTH  SHALL be the combinational read data from the data memory.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-017 A single requesting port SHALL be granted in the same cycle.
REQ-018 When both request, the port not granted most recently SHALL win (round-robin on register last_gnt); the loser's gnt stays 0 and it holds its request.
REQ-019 last_gnt SHALL update to the granted port on every grant and hold otherwise.
REQ-020 The mem_* outputs SHALL mirror the granted port's addr, ctrl and wdata, and SHALL be zero when no grant is active.
REQ-021 mem_we SHALL be high only for a granted, legal store; misaligned or illegal accesses SHALL never assert mem_we.
REQ-022 Misaligned SHALL mean half access with addr[0]=1, or word access with addr[1:0]!=00; illegal SHALL mean ctrl[1:0]=11.
REQ-023 A granted misaligned or illegal access SHALL be consumed: next cycle rvalid=1, err=1, rdata=0.
REQ-024 A granted legal load SHALL register mem_rd into rdata; next cycle rvalid=1, err=0 (latency 1).
REQ-025 A granted legal store SHALL update memory at the grant edge; next cycle rvalid=1, err=0, rdata=0.
REQ-026 A port granted in back-to-back cycles SHALL get back-to-back rvalid pulses, with no bubble.
REQ-027 rvalid, rdata and err SHALL have no backpressure; a requester that misses them loses the data.
REQ-028 Responses SHALL be routed only to the port that was granted, so the non-granted port's rvalid stays 0.
REQ-029 A req dropped before its grant SHALL leave no side effects.

Reset
REQ-030 While rst=1, gnt0/gnt1=0 and mem_we=0 SHALL hold combinationally, regardless of req.
REQ-031 After a reset edge, rvalid*, err* and rdata* SHALL be 0.
REQ-032 After a reset edge, last_gnt SHALL be 1, so port 0 wins the first tie.
REQ-033 Reset asserted in the cycle after a grant SHALL suppress that grant's rvalid.

Verification
REQ-034 Reset, then req0 and req1 both loads in cycle 1 -> gnt0=1 in cycle 1, gnt1=1 in cycle 2, rvalid0 in cycle 2, rvalid1 in cycle 3.
REQ-035 Port1 stores word 0xDEADBEEF to 0x10000, then port0 loads word at 0x10000 -> rdata0=0xDEADBEEF with rvalid0.
REQ-036 Port0 loads byte at 0x10000 holding 0xEF, with ctrl=000 and then ctrl=100 -> rdata0=0xFFFFFFEF, then 0x000000EF.
REQ-037 Port0 stores word at 0x10002 -> mem_we stays 0, next cycle rvalid0=1 and err0=1, and a later read of 0x10000..0x10007 shows no change.
REQ-038 Both ports hold req for 6 cycles -> grants alternate 0,1,0,1,0,1 and gnt0&gnt1 is never 1.
REQ-039 Assert rst one cycle after gnt1 -> rvalid1 stays 0; after release, a tie is granted to port 0.
